// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared encodings and default limits for the two-master memory arbiter.
package bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;
    localparam int TIMEOUT_DEF = 255;
    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between the LSU (m0) and instruction fetch (m1),
// with same-cycle arbitration, fetch starvation relief and a response timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_be_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_be_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        hold_o
);
    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [2:0]  starve_q, starve_d;
    logic        win, cur, act, gnt, in_data, tmo_hit, rv;

    always_comb begin
        win      = (m1_req_i && (!m0_req_i || starve_q == 3'(STARVE_LIMIT))) ? OWNER_M1 : OWNER_M0;
        cur      = state_q == IDLE ? win : owner_q;
        // Gating with rst_n keeps every request-side output low while reset is held.
        act      = rst_n && (state_q == IDLE ? (m0_req_i || m1_req_i) : state_q == ADDR);
        gnt      = act && s_gnt_i;
        in_data  = state_q == DATA;
        tmo_hit  = in_data && !s_rvalid_i && tmo_q == 8'(TIMEOUT - 1);
        rv       = in_data && (s_rvalid_i || tmo_hit);
        s_req_o  = act;
        s_we_o   = act && cur == OWNER_M0 && m0_we_i;
        s_addr_o = !act ? '0 : cur == OWNER_M1 ? m1_addr_i : m0_addr_i;
        s_wdata_o = (act && cur == OWNER_M0) ? m0_wdata_i : '0;
        s_be_o   = !act ? '0 : cur == OWNER_M1 ? 4'hF : m0_be_i;
        m0_gnt_o = gnt && cur == OWNER_M0;
        m1_gnt_o = gnt && cur == OWNER_M1;
        m0_rvalid_o = rv && owner_q == OWNER_M0;
        m1_rvalid_o = rv && owner_q == OWNER_M1;
        m0_err_o = tmo_hit && owner_q == OWNER_M0;
        m1_err_o = tmo_hit && owner_q == OWNER_M1;
        m0_rdata_o = (in_data && s_rvalid_i && owner_q == OWNER_M0) ? s_rdata_i : '0;
        m1_rdata_o = (in_data && s_rvalid_i && owner_q == OWNER_M1) ? s_rdata_i : '0;
        hold_o   = (m1_req_i || (in_data && owner_q == OWNER_M1)) && !m1_rvalid_o;
        state_d  = in_data ? (rv ? IDLE : DATA) : act ? (s_gnt_i ? DATA : ADDR) : state_q;
        owner_d  = act ? cur : owner_q;
        tmo_d    = gnt ? '0 : in_data ? tmo_q + 8'd1 : tmo_q;
        starve_d = !gnt ? starve_q : cur == OWNER_M1 ? '0 :
                   (m1_req_i && starve_q != 3'd7) ? starve_q + 3'd1 : starve_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_M0;
            tmo_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            tmo_q    <= tmo_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic, responses checked
// through per-master expectation queues drained by an independent monitor.
module tb_bus_arbiter;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i;
    logic [3:0]  m0_be_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_gnt_i, s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic        hold_o;

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(255), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .hold_o(hold_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] d);
        mk.err = err;
        mk.rdata = d;
    endfunction

    function automatic logic [31:0] resp(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response must match the oldest expectation of its master.
    always @(negedge clk) begin
        exp_t e;
        if (m0_rvalid_o || m1_rvalid_o) chk("rvalid_excl", 32'(m0_rvalid_o & m1_rvalid_o), 0);
        if (m0_rvalid_o) begin
            if (q0.size() == 0) chk("m0_unexpected_rvalid", 1, 0);
            else begin
                e = q0.pop_front();
                chk("m0_rdata", m0_rdata_o, e.rdata);
                chk("m0_err", 32'(m0_err_o), 32'(e.err));
            end
        end
        if (m1_rvalid_o) begin
            if (q1.size() == 0) chk("m1_unexpected_rvalid", 1, 0);
            else begin
                e = q1.pop_front();
                chk("m1_rdata", m1_rdata_o, e.rdata);
                chk("m1_err", 32'(m1_err_o), 32'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0_st, m1_st, starve_m, dly;
        logic pend;
        logic [31:0] pend_addr;
        rst_n = 1'b0;
        {m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_be_i} = '0;
        {m1_req_i, m1_addr_i, s_gnt_i, s_rvalid_i, s_rdata_i} = '0;
        repeat (2) @(posedge clk);
        #1;
        m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
        @(negedge clk);
        chk("rst_s_req", 32'(s_req_o), 0);
        chk("rst_m0_gnt", 32'(m0_gnt_o), 0);
        chk("rst_m1_gnt", 32'(m1_gnt_o), 0);
        chk("rst_s_addr", s_addr_o, 0);
        chk("rst_hold_req", 32'(hold_o), 1);
        m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0;
        #2;
        chk("rst_hold_idle", 32'(hold_o), 0);
        rst_n = 1'b1;
        nxt();
        // Fetch read, immediate grant, response two cycles later
        m1_req_i = 1; m1_addr_i = 32'h40; s_gnt_i = 1; q1.push_back(mk(1'b0, 32'h13));
        @(negedge clk);
        chk("r31_gnt", 32'(m1_gnt_o), 1);
        chk("r31_hold0", 32'(hold_o), 1);
        chk("r31_addr", s_addr_o, 32'h40);
        chk("r31_be", 32'(s_be_o), 32'hF);
        chk("r31_we", 32'(s_we_o), 0);
        nxt(); m1_req_i = 0; s_gnt_i = 0;
        @(negedge clk);
        chk("r31_hold1", 32'(hold_o), 1);
        chk("r31_sreq_data", 32'(s_req_o), 0);
        nxt(); s_rvalid_i = 1; s_rdata_i = 32'h13;
        @(negedge clk);
        chk("r31_rvalid", 32'(m1_rvalid_o), 1);
        chk("r31_hold2", 32'(hold_o), 0);
        nxt(); s_rvalid_i = 0; s_rdata_i = 0;
        // Simultaneous LSU write and fetch
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h100; m0_wdata_i = 32'hDEADBEEF; m0_be_i = 4'b0011;
        m1_req_i = 1; m1_addr_i = 32'h200; s_gnt_i = 1; q0.push_back(mk(1'b0, 32'h1111_1111));
        @(negedge clk);
        chk("r32_m0_gnt", 32'(m0_gnt_o), 1);
        chk("r32_m1_gnt", 32'(m1_gnt_o), 0);
        chk("r32_addr", s_addr_o, 32'h100);
        chk("r32_be", 32'(s_be_o), 32'h3);
        chk("r32_we", 32'(s_we_o), 1);
        chk("r32_wdata", s_wdata_o, 32'hDEADBEEF);
        nxt(); m0_req_i = 0; m0_we_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h1111_1111;
        @(negedge clk);
        chk("r32_data_m1_gnt", 32'(m1_gnt_o), 0);
        chk("r32_data_sreq", 32'(s_req_o), 0);
        nxt(); s_rvalid_i = 0; q1.push_back(mk(1'b0, 32'h2222_2222));
        @(negedge clk);
        chk("r32_m1_gnt_late", 32'(m1_gnt_o), 1);
        chk("r32_m1_addr", s_addr_o, 32'h200);
        nxt(); m1_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h2222_2222;
        @(negedge clk);
        nxt(); s_rvalid_i = 0;
        // Continuous contention: fetch must win the fifth arbitration, then the count restarts
        m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h1000; m1_addr_i = 32'h2000;
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) q1.push_back(mk(1'b0, 32'(k)));
            else q0.push_back(mk(1'b0, 32'(k)));
            @(negedge clk);
            chk($sformatf("r33_m1_gnt_%0d", k), 32'(m1_gnt_o), 32'(k == 5));
            chk($sformatf("r33_m0_gnt_%0d", k), 32'(m0_gnt_o), 32'(k != 5));
            nxt(); s_rvalid_i = 1; s_rdata_i = 32'(k);
            @(negedge clk);
            nxt(); s_rvalid_i = 0;
        end
        m0_req_i = 0; m1_req_i = 0;
        // Slow grant: fetch owner keeps the bus while LSU waits
        s_gnt_i = 0; m1_req_i = 1; m1_addr_i = 32'h300; q1.push_back(mk(1'b0, 32'h33));
        @(negedge clk);
        chk("r34_addr0", s_addr_o, 32'h300);
        chk("r34_nogrant", 32'(m1_gnt_o), 0);
        nxt(); m0_req_i = 1; m0_addr_i = 32'h500; q0.push_back(mk(1'b0, 32'h44));
        s_rvalid_i = 1; s_rdata_i = 32'hBAD0_0001;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("r34_addr_locked", s_addr_o, 32'h300);
            chk("r34_m0_no_gnt", 32'(m0_gnt_o), 0);
            chk("r34_addr_rvalid_ignored", 32'(m1_rvalid_o), 0);
            nxt(); s_rvalid_i = 0;
        end
        s_gnt_i = 1;
        @(negedge clk);
        chk("r34_m1_gnt", 32'(m1_gnt_o), 1);
        chk("r34_m0_gnt", 32'(m0_gnt_o), 0);
        chk("r34_addr3", s_addr_o, 32'h300);
        nxt(); m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h33;
        @(negedge clk);
        nxt(); s_rvalid_i = 0; s_gnt_i = 1;
        @(negedge clk);
        chk("r34_m0_after", 32'(m0_gnt_o), 1);
        chk("r34_m0_addr", s_addr_o, 32'h500);
        nxt(); m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h44;
        @(negedge clk);
        nxt(); s_rvalid_i = 0;
        // Timeout: no response ever arrives, a late one is ignored
        m0_req_i = 1; m0_addr_i = 32'h600; s_gnt_i = 1; q0.push_back(mk(1'b1, 32'h0));
        @(negedge clk);
        chk("r35_gnt", 32'(m0_gnt_o), 1);
        nxt(); m0_req_i = 0; s_gnt_i = 0; s_rdata_i = 32'hFFFF_FFFF;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            chk($sformatf("r35_rvalid_c%0d", k), 32'(m0_rvalid_o), 32'(k == 255));
            if (k == 255) begin
                chk("r35_err", 32'(m0_err_o), 1);
                chk("r35_rdata", m0_rdata_o, 0);
            end
            nxt();
        end
        @(negedge clk);
        nxt(); s_rvalid_i = 1; s_rdata_i = 32'hBAD0_0002;
        @(negedge clk);
        chk("r35_late_m0", 32'(m0_rvalid_o), 0);
        chk("r35_late_m1", 32'(m1_rvalid_o), 0);
        nxt(); s_rvalid_i = 0;
        // Reset during DATA abandons the access
        m0_req_i = 1; m0_addr_i = 32'h700; s_gnt_i = 1;
        @(negedge clk);
        chk("r36_gnt", 32'(m0_gnt_o), 1);
        nxt(); #2;
        rst_n = 0; s_rvalid_i = 1; s_rdata_i = 32'hBAD0_0003;
        #1;
        chk("r36_sreq", 32'(s_req_o), 0);
        chk("r36_gnt_rst", 32'(m0_gnt_o), 0);
        chk("r36_rvalid_rst", 32'(m0_rvalid_o), 0);
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 0;
        @(negedge clk);
        rst_n = 1;
        nxt();
        m0_req_i = 1; m0_addr_i = 32'h800; q0.push_back(mk(1'b0, 32'h55));
        @(negedge clk);
        chk("r36_new_req", 32'(s_req_o), 1);
        chk("r36_new_addr", s_addr_o, 32'h800);
        chk("r36_new_nogrant", 32'(m0_gnt_o), 0);
        nxt(); s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'hBAD0_0004;
        @(negedge clk);
        chk("r36_new_gnt", 32'(m0_gnt_o), 1);
        chk("r36_stale_rvalid", 32'(m0_rvalid_o), 0);
        nxt(); m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h55;
        @(negedge clk);
        nxt(); s_rvalid_i = 0;
        // Randomized traffic with a tb-side slave
        m0_st = 0; m1_st = 0; starve_m = 0; pend = 0; pend_addr = 0; dly = 0;
        for (int c = 0; c < 3400; c++) begin
            m0_req_i = m0_st == 1;
            m1_req_i = m1_st == 1;
            if (c < 3000 && m0_st == 0 && $urandom_range(0, 2) == 0) begin
                m0_req_i = 1; m0_we_i = 1'($urandom); m0_addr_i = $urandom;
                m0_wdata_i = $urandom; m0_be_i = 4'($urandom);
                q0.push_back(mk(1'b0, resp(m0_addr_i)));
                m0_st = 1;
            end
            if (c < 3000 && m1_st == 0 && $urandom_range(0, 1) == 0) begin
                m1_req_i = 1; m1_addr_i = $urandom;
                q1.push_back(mk(1'b0, resp(m1_addr_i)));
                m1_st = 1;
            end
            s_gnt_i = $urandom_range(0, 3) != 0;
            if (pend) begin
                dly--;
                s_rvalid_i = dly == 0;
                s_rdata_i = resp(pend_addr);
                if (dly == 0) pend = 0;
            end else begin
                s_rvalid_i = $urandom_range(0, 7) == 0;
                s_rdata_i = $urandom;
            end
            @(negedge clk);
            chk("rnd_gnt_excl", 32'(m0_gnt_o & m1_gnt_o), 0);
            chk("rnd_hold", 32'(hold_o), 32'((m1_req_i | (m1_st == 2)) & ~m1_rvalid_o));
            if (m0_gnt_o) begin
                chk("rnd_m0_gnt_req", 32'(m0_st), 1);
                chk("rnd_m0_addr", s_addr_o, m0_addr_i);
                chk("rnd_m0_we", 32'(s_we_o), 32'(m0_we_i));
                chk("rnd_m0_be", 32'(s_be_o), 32'(m0_be_i));
                chk("rnd_m0_wdata", s_wdata_o, m0_wdata_i);
                if (m1_req_i) begin
                    chk("rnd_starve", 32'(starve_m < STARVE_LIMIT), 1);
                    starve_m++;
                end
                m0_st = 2;
            end
            if (m1_gnt_o) begin
                chk("rnd_m1_gnt_req", 32'(m1_st), 1);
                chk("rnd_m1_addr", s_addr_o, m1_addr_i);
                chk("rnd_m1_we", 32'(s_we_o), 0);
                chk("rnd_m1_be", 32'(s_be_o), 32'hF);
                chk("rnd_m1_wdata", s_wdata_o, 0);
                starve_m = 0;
                m1_st = 2;
            end
            if (s_req_o && s_gnt_i) begin
                pend = 1; pend_addr = s_addr_o; dly = $urandom_range(1, 3);
            end
            if (m0_rvalid_o) m0_st = 0;
            if (m1_rvalid_o) m1_st = 0;
            nxt();
        end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_m0", 32'(m0_st), 0);
        chk("drain_m1", 32'(m1_st), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: DATA-phase cycles allowed before an error response.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive contested m0 grants before m1 is forced to win.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 m0_req_i / m0_we_i  input  1/1  data master (LSU) request and write enable.
REQ-006 m0_addr_i / m0_wdata_i / m0_be_i  input  32/32/4  data master address, write data and byte enables.
REQ-007 m0_gnt_o / m0_rvalid_o / m0_err_o  output  1/1/1  data master grant, response valid and error.
REQ-008 m0_rdata_o  output  32  data master read data.
REQ-009 m1_req_i / m1_addr_i  input  1/32  fetch master (ifetch); read-only request and address.
REQ-010 m1_gnt_o / m1_rvalid_o / m1_err_o / m1_rdata_o  output  1/1/1/32  fetch master grant, response, error and data.
REQ-011 s_req_o / s_we_o / s_addr_o / s_wdata_o / s_be_o  output  1/1/32/32/4  shared memory request.
REQ-012 s_gnt_i / s_rvalid_i / s_rdata_i  input  1/1/32  shared memory grant, response valid and read data.
REQ-013 hold_o  output  1  stall to pc_reg and if_id while a fetch is pending.

Function
REQ-014 States: IDLE, ADDR, DATA; registered owner bit (0 = m0, 1 = m1).
REQ-015 Arbitration in IDLE is combinational and same-cycle:
- m0 wins over m1;
- exception: m1 wins if m1_req_i=1 and starve_cnt == STARVE_LIMIT.
REQ-016 In IDLE with any request, the winner's fields drive s_*, with s_req_o=1.
- s_gnt_i=1: asserts winner's gnt for that cycle; next state DATA.
- s_gnt_i=0: next state ADDR, owner latched.
REQ-017 ADDR: owner stays locked (no re-arbitration) and the owner's fields drive s_*, with s_req_o=1; s_gnt_i=1 -> owner gnt for one cycle, next state DATA.
REQ-018 Masters hold req and request fields stable until their gnt; the arbiter does not check this.
REQ-019 DATA: s_req_o=0.
- s_rvalid_i=1: same cycle, owner rvalid=1 and rdata=s_rdata_i; next state IDLE.
- No new request is issued in the DATA cycle; one idle bubble is permitted.
REQ-020 m1 accesses drive s_we_o=0, s_be_o=4'hF, s_wdata_o=0.
REQ-021 Timeout counter (8 bit):
- clears on entry to DATA and increments each DATA cycle without s_rvalid_i;
- on reaching TIMEOUT: owner rvalid=1, err=1, rdata=0; next state IDLE.
REQ-022 s_rvalid_i received outside DATA is ignored, including a late response after a timeout.
REQ-023 Starvation counter (3 bit, saturating):
- increments on each m0 grant issued while m1_req_i=1;
- clears on any m1 grant.
REQ-024 hold_o=1 when m1_req_i=1 and no m1 rvalid occurs that cycle, or when owner=1 in DATA with no m1 rvalid that cycle; otherwise hold_o=0.
REQ-025 A non-owner master never sees gnt or rvalid; outputs of the idle master are 0.
REQ-026 When idle, s_* outputs are 0.

Reset
REQ-027 rst_n low asynchronously forces:
- state IDLE, owner 0, both counters 0;
- all outputs 0 (hold_o follows REQ-024 combinationally).
REQ-028 Reset in ADDR or DATA abandons the transaction; no rvalid is produced for it.

Structure
REQ-029 State encoding, owner encoding and the default TIMEOUT and STARVE_LIMIT values live in the shared core defines package.
REQ-030 Single module with no sub-module; it is instantiated between ifetch/LSU and the ROM/RAM in riscv_core.

Verification
REQ-031 m1 read only, s_gnt_i immediate, s_rvalid_i +2 cycles with data 0x00000013:
- m1_gnt_o in cycle 0;
- m1_rvalid_o and m1_rdata_o=0x00000013 in cycle 2;
- hold_o high in cycles 0-1, low in cycle 2.
REQ-032 m0 write (addr 0x100, wdata 0xDEADBEEF, be 4'b0011) and m1 read in the same cycle:
- s_addr_o=0x100, s_be_o=4'b0011;
- m0 granted first, m1 granted after m0 rvalid plus one bubble.
REQ-033 m0 and m1 requesting continuously: m1 granted on the 5th arbitration; starve_cnt then 0.
REQ-034 s_gnt_i held low 3 cycles: s_addr_o stays at the owner's address; m0 requesting meanwhile does not preempt an m1 owner.
REQ-035 No s_rvalid_i after grant:
- at DATA cycle 255, owner rvalid=1, err=1, rdata=0;
- an s_rvalid_i injected 2 cycles later is ignored.
REQ-036 rst_n pulsed low in DATA: outputs 0 immediately; after release, the next request starts in IDLE and the abandoned transaction produces no rvalid.
